axi_lite_mem_slave: RTL and testbench
=====================================

Name: axi_lite_mem_slave

Overview:
- AXI-Lite responder (slave) backed by a word-addressed scratchpad RAM.
- It is the responder end of the AXI-Lite link driven by the RISC-V core's AXI-Lite master.
- It sits beside the AXI-to-APB bridge on the interconnect as a second target, and serves as a directly attached memory-mapped data store for firmware and for bring-up.
- Write and read channels run independent state machines, with address decode, byte strobes, SLVERR responses and saturating transaction counters.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, data width; fixed at 32, with 4 strobe bits.
- DEPTH_WORDS, 256, RAM depth in 32-bit words; must be a power of 2.
- BASE_ADDR, 32'h0000_2000, byte base address of the window.
- WAIT_CYCLES, 2, extra response delay; used only when AXIL_MEM_WAIT_EN is defined.

Ports:
- aclk  in  1  clock
- areset_n  in  1  asynchronous active-low reset
- s_awaddr  in  ADDR_WIDTH  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- s_araddr  in  ADDR_WIDTH  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- wr_count  out  16  accepted writes, saturating at 16'hFFFF
- rd_count  out  16  accepted reads, saturating at 16'hFFFF

Behaviour:

Clock and reset:
- One clock, aclk.
- Reset is asynchronous and active-low on areset_n.

Reset values:
- s_awready, s_wready, s_arready, s_bvalid and s_rvalid = 0.
- s_bresp and s_rresp = 2'b00.
- s_rdata = 0.
- wr_count and rd_count = 0.
- RAM contents are not reset.
- Readies rise at the first aclk edge after areset_n deasserts.

Address decode:
- An address hits when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS and addr[1:0] == 0.
- Word index = (addr - BASE_ADDR) >> 2.
- A miss or a misaligned address gives SLVERR (2'b10). The write is dropped; read data is 0.

Write FSM states: W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP.
- W_IDLE: awready = 1 and wready = 1.
  - AW and W handshake in the same cycle -> commit, go to W_RESP.
  - AW only -> latch address, go to W_WAIT_W (awready = 0).
  - W only -> latch data and strobe, go to W_WAIT_AW (wready = 0).
- W_WAIT_W / W_WAIT_AW: on the missing handshake -> commit, go to W_RESP.
- Commit: only lanes with wstrb[i] = 1 update byte i. wstrb = 0 is a legal no-op returning OKAY.
- W_RESP: bvalid = 1 and awready = wready = 0. bresp is held stable until bready. On bvalid & bready -> W_IDLE.
- Latency: bvalid asserts the cycle after the last of the AW/W handshakes.
- wr_count increments at commit, including SLVERR commits.

Read FSM states: R_IDLE, R_RESP.
- R_IDLE: arready = 1. On handshake, the RAM is read registered; go to R_RESP.
- R_RESP: rvalid = 1 and arready = 0. rdata and rresp are held until rready. On rvalid & rready -> R_IDLE.
- Latency: rvalid asserts 1 cycle after the AR handshake.
- rd_count increments at the AR handshake.

Channel interaction:
- The write and read FSMs are fully concurrent.
- A read and a committing write to the same word in the same cycle: the read returns the pre-write data.

Boundaries:
- Both counters saturate at 16'hFFFF and do not wrap.
- A valid dropped before its handshake is ignored; no protocol checking is done.
- areset_n asserting mid-transaction aborts it immediately. The pending response is discarded, and a partially written word keeps any lanes already written.

Optional Feature:
- Macro: AXIL_MEM_WAIT_EN.
- Defined: bvalid and rvalid assert WAIT_CYCLES cycles later than the base latency, counted by a per-channel down-counter loaded on entry to the response state. This exercises master stall paths.
- Undefined: no counter logic; latencies are exactly as specified in Behaviour.

Decomposition:
- Shared package axi_lite_pkg holds:
  - resp_t enum: OKAY = 2'b00, SLVERR = 2'b10.
  - the write-state and read-state enums.
  - the default BASE_ADDR constant.
- One sub-module: axi_lite_mem_ram.
  - Single-clock RAM with one byte-enable write port and one registered read port.
  - Read-before-write on same-address collision.

Test Plan:
1. Reset, then AW and W in the same cycle: addr 32'h2000, data 32'hDEADBEEF, strb 4'hF -> bvalid the next cycle, bresp 00, wr_count 1. Read 32'h2000 -> rvalid 1 cycle after AR, rdata 32'hDEADBEEF, rresp 00.
2. W three cycles before AW (addr 32'h2004, data 32'h11223344), then a second write with strb 4'b0101 and data 32'hAABBCCDD -> readback 32'h11BB33DD.
3. Out-of-range write to 32'h3000 and misaligned read of 32'h2002 -> bresp 10 with RAM unchanged; rresp 10 with rdata 0.
4. Hold bready = 0 and rready = 0 for 5 cycles -> bvalid, rvalid, bresp, rresp and rdata stay stable; awready, wready and arready stay 0 until the responses are accepted.
5. Same-cycle read and write to 32'h2008 (old value 32'h0, new value 32'h5A5A5A5A) -> read returns 32'h0; a following read returns 32'h5A5A5A5A.
6. With AXIL_MEM_WAIT_EN defined and WAIT_CYCLES = 2 -> bvalid 3 cycles after the last handshake. Separately, assert areset_n = 0 during W_RESP -> bvalid drops immediately and the FSM restarts in W_IDLE.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types and defaults for the AXI-Lite scratchpad responder.
package axi_lite_pkg;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;
  localparam logic [31:0] AXIL_BASE_ADDR = 32'h0000_2000;
endpackage

// File: rtl/axi_lite_mem_ram.sv
// Word RAM: one byte-enable write port, one registered read port.
// Same-address collision returns the old word (read-before-write).
module axi_lite_mem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI-Lite responder over a word scratchpad; independent write/read FSMs.
// Define AXIL_MEM_WAIT_EN to delay bvalid/rvalid by WAIT_CYCLES.
module axi_lite_mem_slave import axi_lite_pkg::*; #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(AXIL_BASE_ADDR),
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [15:0]             wr_count,
  output logic [15:0]             rd_count
);
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(4 * DEPTH_WORDS);

  function automatic logic hit(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < WIN_BYTES) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> 2);
  endfunction

`ifdef AXIL_MEM_WAIT_EN
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);
  logic [CNT_W-1:0] w_cnt, r_cnt;
`endif

  wstate_t wstate;
  rstate_t rstate;
  logic aw_rdy, w_rdy, b_vld, ar_rdy, r_vld, r_hit;
  resp_t b_resp, r_resp;
  logic [ADDR_WIDTH-1:0] aw_q, c_addr;
  logic [31:0] wd_q, c_data, ram_rdata;
  logic [3:0]  ws_q, c_strb;
  logic aw_hs, w_hs, ar_hs, commit;

  assign aw_hs = s_awvalid & aw_rdy;
  assign w_hs  = s_wvalid & w_rdy;
  assign ar_hs = s_arvalid & ar_rdy;

  // Commit operands come from the bus for whichever half arrives last.
  always_comb begin
    commit = 1'b0;
    c_addr = aw_q;
    c_data = wd_q;
    c_strb = ws_q;
    case (wstate)
      W_IDLE:    begin commit = aw_hs & w_hs; c_addr = s_awaddr; c_data = s_wdata; c_strb = s_wstrb; end
      W_WAIT_W:  begin commit = w_hs; c_data = s_wdata; c_strb = s_wstrb; end
      W_WAIT_AW: begin commit = aw_hs; c_addr = s_awaddr; end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) begin
      wstate <= W_IDLE; aw_rdy <= 1'b0; w_rdy <= 1'b0; b_vld <= 1'b0; b_resp <= OKAY;
      aw_q <= '0; wd_q <= '0; ws_q <= '0; wr_count <= '0;
`ifdef AXIL_MEM_WAIT_EN
      w_cnt <= '0;
`endif
    end else if (commit) begin
      wstate   <= W_RESP;
      aw_rdy   <= 1'b0;
      w_rdy    <= 1'b0;
      b_resp   <= hit(c_addr) ? OKAY : SLVERR;
      wr_count <= wr_count + {15'd0, ~&wr_count};
`ifdef AXIL_MEM_WAIT_EN
      b_vld    <= (WAIT_CYCLES == 0);
      w_cnt    <= WAIT_LD;
`else
      b_vld    <= 1'b1;
`endif
    end else begin
      case (wstate)
        W_IDLE:
          if (aw_hs)     begin aw_q <= s_awaddr; aw_rdy <= 1'b0; wstate <= W_WAIT_W; end
          else if (w_hs) begin wd_q <= s_wdata; ws_q <= s_wstrb; w_rdy <= 1'b0; wstate <= W_WAIT_AW; end
          else           begin aw_rdy <= 1'b1; w_rdy <= 1'b1; end
        W_RESP:
          if (b_vld && s_bready) begin
            b_vld <= 1'b0; aw_rdy <= 1'b1; w_rdy <= 1'b1; wstate <= W_IDLE;
          end
`ifdef AXIL_MEM_WAIT_EN
          else if (!b_vld) begin
            if (w_cnt <= CNT_W'(1)) b_vld <= 1'b1;
            else                    w_cnt <= w_cnt - CNT_W'(1);
          end
`endif
        default: ;
      endcase
    end

  always_ff @(posedge aclk or negedge areset_n)
    if (!areset_n) begin
      rstate <= R_IDLE; ar_rdy <= 1'b0; r_vld <= 1'b0; r_resp <= OKAY; r_hit <= 1'b0; rd_count <= '0;
`ifdef AXIL_MEM_WAIT_EN
      r_cnt <= '0;
`endif
    end else begin
      case (rstate)
        R_IDLE:
          if (ar_hs) begin
            rstate   <= R_RESP;
            ar_rdy   <= 1'b0;
            r_hit    <= hit(s_araddr);
            r_resp   <= hit(s_araddr) ? OKAY : SLVERR;
            rd_count <= rd_count + {15'd0, ~&rd_count};
`ifdef AXIL_MEM_WAIT_EN
            r_vld    <= (WAIT_CYCLES == 0);
            r_cnt    <= WAIT_LD;
`else
            r_vld    <= 1'b1;
`endif
          end else ar_rdy <= 1'b1;
        R_RESP:
          if (r_vld && s_rready) begin
            r_vld <= 1'b0; ar_rdy <= 1'b1; rstate <= R_IDLE;
          end
`ifdef AXIL_MEM_WAIT_EN
          else if (!r_vld) begin
            if (r_cnt <= CNT_W'(1)) r_vld <= 1'b1;
            else                    r_cnt <= r_cnt - CNT_W'(1);
          end
`endif
        default: ;
      endcase
    end

  axi_lite_mem_ram #(.DEPTH(DEPTH_WORDS)) u_ram (
    .clk   (aclk),
    .rst_n (areset_n),
    .we    ((commit && hit(c_addr)) ? c_strb : 4'b0000),
    .waddr (idx(c_addr)),
    .wdata (c_data),
    .re    (ar_hs && hit(s_araddr)),
    .raddr (idx(s_araddr)),
    .rdata (ram_rdata)
  );

  assign s_awready = aw_rdy;
  assign s_wready  = w_rdy;
  assign s_bvalid  = b_vld;
  assign s_bresp   = b_resp;
  assign s_arready = ar_rdy;
  assign s_rvalid  = r_vld;
  assign s_rresp   = r_resp;
  // Misses read as zero; the RAM port is only enabled on a hit.
  assign s_rdata   = r_hit ? ram_rdata : '0;
endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Bench for axi_lite_mem_slave: directed cases plus randomized traffic vs a word-array model.
module tb_axi_lite_mem_slave;
  localparam logic [31:0] BASE = 32'h0000_2000;
  localparam int DEPTH = 256;
`ifdef AXIL_MEM_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic aclk = 1'b0, areset_n = 1'b0;
  logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0, s_rdata;
  logic [3:0]  s_wstrb = '0;
  logic s_awvalid = 1'b0, s_wvalid = 1'b0, s_bready = 1'b0, s_arvalid = 1'b0, s_rready = 1'b0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [15:0] wr_count, rd_count;

  axi_lite_mem_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
                       .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .wr_count(wr_count), .rd_count(rd_count));

  always #5 aclk = ~aclk;

  // Cycle stamps of each handshake, for latency measurement.
  int cyc = 0, aw_cyc = 0, w_cyc = 0, ar_cyc = 0;
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (s_awvalid && s_awready) aw_cyc <= cyc;
    if (s_wvalid && s_wready)   w_cyc  <= cyc;
    if (s_arvalid && s_arready) ar_cyc <= cyc;
  end

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model
  logic [31:0] mem_m [DEPTH];
  int wr_n = 0, rd_n = 0;

  function automatic bit in_win(input logic [31:0] a);
    return a >= BASE && a < BASE + 32'(4 * DEPTH) && a[1:0] == 2'b00;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return in_win(a) ? mem_m[(a - BASE) / 4] : 32'h0;
  endfunction

  task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_win(a))
      for (int i = 0; i < 4; i++)
        if (s[i]) mem_m[(a - BASE) / 4][8*i +: 8] = d[8*i +: 8];
  endtask

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int stall);
    logic [1:0] er;
    er = in_win(a) ? 2'b00 : 2'b10;
    model_wr(a, d, s);
    wr_n++;
    fork
      begin
        repeat (aw_dly) @(negedge aclk);
        s_awaddr = a; s_awvalid = 1'b1;
        for (int t = 0; t < 50 && !s_awready; t++) @(negedge aclk);
        chk("aw_ready", s_awready, 1);
        @(negedge aclk); s_awvalid = 1'b0;
      end
      begin
        repeat (w_dly) @(negedge aclk);
        s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
        for (int t = 0; t < 50 && !s_wready; t++) @(negedge aclk);
        chk("w_ready", s_wready, 1);
        @(negedge aclk); s_wvalid = 1'b0;
      end
    join
    for (int t = 0; t < 50 && !s_bvalid; t++) @(negedge aclk);
    chk("bvalid", s_bvalid, 1);
    chk("b_latency", cyc - mx(aw_cyc, w_cyc), LAT);
    chk("bresp", s_bresp, er);
    repeat (stall) begin
      @(negedge aclk);
      chk("b_hold", {s_bvalid, s_bresp}, {1'b1, er});
      chk("aw_w_blocked", {s_awready, s_wready}, 0);
    end
    s_bready = 1'b1;
    @(negedge aclk);
    s_bready = 1'b0;
    chk("bvalid_clr", s_bvalid, 0);
    chk("wr_count", wr_count, wr_n);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] ed, input int ar_dly, input int stall);
    logic [1:0] er;
    er = in_win(a) ? 2'b00 : 2'b10;
    rd_n++;
    repeat (ar_dly) @(negedge aclk);
    s_araddr = a; s_arvalid = 1'b1;
    for (int t = 0; t < 50 && !s_arready; t++) @(negedge aclk);
    chk("ar_ready", s_arready, 1);
    @(negedge aclk); s_arvalid = 1'b0;
    for (int t = 0; t < 50 && !s_rvalid; t++) @(negedge aclk);
    chk("rvalid", s_rvalid, 1);
    chk("r_latency", cyc - ar_cyc, LAT);
    chk("rresp", s_rresp, er);
    chk("rdata", s_rdata, ed);
    repeat (stall) begin
      @(negedge aclk);
      chk("r_hold", {s_rvalid, s_rresp}, {1'b1, er});
      chk("r_hold_data", s_rdata, ed);
      chk("ar_blocked", s_arready, 0);
    end
    s_rready = 1'b1;
    @(negedge aclk);
    s_rready = 1'b0;
    chk("rvalid_clr", s_rvalid, 0);
    chk("rd_count", rd_count, rd_n);
  endtask

  initial begin
    logic [31:0] a, d, old;
    int r;
    repeat (3) @(negedge aclk);
    chk("rst_readies", {s_awready, s_wready, s_arready}, 0);
    chk("rst_valids", {s_bvalid, s_rvalid}, 0);
    chk("rst_resps", {s_bresp, s_rresp}, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_counts", {wr_count, rd_count}, 0);
    areset_n = 1'b1;
    #1 chk("ready_before_edge", s_awready, 0);
    @(negedge aclk);
    chk("ready_after_edge", {s_awready, s_wready, s_arready}, 3'b111);

    // Known contents for the words the random phase touches.
    for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), 32'h0, 4'hF, 0, 0, 0);

    // 1: simultaneous AW/W, then readback
    do_write(32'h2000, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h2000, 32'hDEADBEEF, 0, 0);
    // 2: W leads AW by three cycles, then a partial-strobe overwrite
    do_write(32'h2004, 32'h11223344, 4'hF, 3, 0, 0);
    do_write(32'h2004, 32'hAABBCCDD, 4'b0101, 0, 2, 0);
    do_read(32'h2004, 32'h11BB33DD, 0, 0);
    // 3: out-of-window write (would alias word 0 if decode were loose), misaligned read
    do_write(32'h3000, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_read(32'h2000, 32'hDEADBEEF, 0, 0);
    do_read(32'h2002, 32'h0, 0, 0);
    // 4: long response stalls
    do_write(32'h2010, 32'h01020304, 4'hF, 0, 0, 5);
    do_read(32'h2010, 32'h01020304, 0, 5);
    // 5: same-cycle read and write of one word
    old = model_rd(32'h2008);
    fork
      do_write(32'h2008, 32'h5A5A5A5A, 4'hF, 0, 0, 0);
      do_read(32'h2008, old, 0, 0);
    join
    chk("collision_old", old, 32'h0);
    do_read(32'h2008, 32'h5A5A5A5A, 0, 0);

    // 6: reset while a write response is pending
    model_wr(32'h200C, 32'h77778888, 4'hF);
    s_awaddr = 32'h200C; s_wdata = 32'h77778888; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge aclk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int t = 0; t < 50 && !s_bvalid; t++) @(negedge aclk);
    chk("pre_rst_bvalid", s_bvalid, 1);
    #2 areset_n = 1'b0;
    #1 chk("rst_bvalid_drop", s_bvalid, 0);
    chk("rst_wr_count", wr_count, 0);
    @(negedge aclk);
    areset_n = 1'b1;
    wr_n = 0; rd_n = 0;
    @(negedge aclk);
    chk("restart_idle", {s_awready, s_wready}, 2'b11);
    do_read(32'h200C, 32'h77778888, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 19));
      case (r)
        16:      a = 32'h3000;
        17:      a = BASE - 32'd4;
        18:      a = BASE + 32'd2;
        19:      a = BASE + 32'(4 * DEPTH);
        default: a = BASE + 32'(4 * r);
      endcase
      if ($urandom_range(0, 1) == 0) begin
        d = $urandom();
        do_write(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else
        do_read(a, model_rd(a), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
